// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction fetch interface. Issues one bus read per fetch,
//               buffers the returned word and hands it to the ID stage under
//               control of the CTRL stall vector and exception flush.
//               Optional macro FETCH_ADDR_ERR_EN: misaligned fetch addresses
//               skip the bus and are passed to ID as an address error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        stallreq_if,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t      state;
  logic        discard;
  logic [31:0] buf_inst;
  logic        drop_now;
  logic        unused_stall_bits;

  // Only the IF/ID and ID hold bits of the stall vector matter here.
  assign unused_stall_bits = ^{stall[5:3], stall[0]};

  // A flush arriving in the same cycle as the data must also drop it.
  assign drop_now = discard | flush;

  // Stall the pipeline whenever a fetch is wanted but no word is ready.
  always_comb stallreq_if = ce && (state != S_FULL);

  // Fetch FSM: request address, wait for data, hold it until ID takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      discard   <= 1'b0;
      inst_req  <= 1'b0;
      inst_addr <= 32'h0;
      buf_inst  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ce && !flush) begin
            inst_addr <= pc;
`ifdef FETCH_ADDR_ERR_EN
            if (pc[1:0] != 2'b00) begin
              // Misaligned: no bus cycle, deliver an empty word flagged as AdEL.
              buf_inst <= 32'h0;
              state    <= S_FULL;
            end else begin
              inst_req <= 1'b1;
              state    <= S_ADDR;
            end
`else
            inst_req <= 1'b1;
            state    <= S_ADDR;
`endif
          end
        end
        S_ADDR: begin
          if (inst_addr_ok) begin
            inst_req <= 1'b0;
            if (inst_data_ok) begin
              discard <= 1'b0;
              if (drop_now) begin
                state <= S_IDLE;
              end else begin
                buf_inst <= inst_rdata;
                state    <= S_FULL;
              end
            end else begin
              discard <= drop_now;
              state   <= S_DATA;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        S_DATA: begin
          if (inst_data_ok) begin
            discard <= 1'b0;
            if (drop_now) begin
              state <= S_IDLE;
            end else begin
              buf_inst <= inst_rdata;
              state    <= S_FULL;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        S_FULL: begin
          // Either ID consumes the word or a flush throws it away.
          if (flush || !stall[1]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IF/ID payload register: flush clears, stall holds or bubbles, else load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
    end else if (stall[1]) begin
      if (!stall[2]) begin
        id_inst  <= 32'h0;
        id_valid <= 1'b0;
      end
    end else if (state == S_FULL) begin
      id_pc    <= inst_addr;
      id_inst  <= buf_inst;
      id_valid <= 1'b1;
    end else begin
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
    end
  end

`ifdef FETCH_ADDR_ERR_EN
  logic buf_adel;

  // Remember whether the word being fetched came from a misaligned address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_adel <= 1'b0;
    end else if ((state == S_IDLE) && ce && !flush) begin
      buf_adel <= (pc[1:0] != 2'b00);
    end
  end

  // Address-error flag follows the same flush/stall rules as the payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_adel <= 1'b0;
    end else if (flush) begin
      id_adel <= 1'b0;
    end else if (stall[1]) begin
      if (!stall[2]) begin
        id_adel <= 1'b0;
      end
    end else if (state == S_FULL) begin
      id_adel <= buf_adel;
    end else begin
      id_adel <= 1'b0;
    end
  end
`else
  assign id_adel = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_if.sv
// ============================================================================
// Module      : tb_inst_fetch_if
// Description : Directed bench for inst_fetch_if with a transaction-level
//               reference model checked every cycle plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  int nvec = 0;
  int nerr = 0;

  inst_fetch_if dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .stallreq_if  (stallreq_if),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, transaction view: one outstanding bus read (address
  // phase or data phase), an optional "drop" mark, and a one-word slot
  // holding a fetched word that ID has not yet taken.
  logic        m_req, m_wait, m_drop, m_ready, m_ra;
  logic [31:0] m_addr, m_rp, m_ri;
  logic [31:0] m_id_pc, m_id_inst;
  logic        m_id_valid, m_id_adel;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req = 0; m_wait = 0; m_drop = 0; m_ready = 0; m_ra = 0;
      m_addr = 0; m_rp = 0; m_ri = 0;
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
    end else begin
      // What ID sees after this edge, from the slot contents before it.
      if (flush) begin
        m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
      end else if (stall[1]) begin
        if (!stall[2]) begin
          m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
        end
      end else if (m_ready) begin
        m_id_pc = m_rp; m_id_inst = m_ri; m_id_valid = 1; m_id_adel = m_ra;
      end else begin
        m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
      end
      // Advance the fetch transaction.
      if (m_ready) begin
        if (flush || !stall[1]) m_ready = 0;
      end else if (m_req) begin
        if (inst_addr_ok) begin
          m_req = 0;
          if (inst_data_ok) begin
            if (!(m_drop || flush)) begin
              m_ready = 1; m_ri = inst_rdata; m_rp = m_addr;
            end
            m_drop = 0;
          end else begin
            m_wait = 1;
            m_drop = m_drop || flush;
          end
        end else if (flush) begin
          m_drop = 1;
        end
      end else if (m_wait) begin
        if (inst_data_ok) begin
          m_wait = 0;
          if (!(m_drop || flush)) begin
            m_ready = 1; m_ri = inst_rdata; m_rp = m_addr;
          end
          m_drop = 0;
        end else if (flush) begin
          m_drop = 1;
        end
      end else if (ce && !flush) begin
`ifdef FETCH_ADDR_ERR_EN
        if (pc[1:0] != 2'b00) begin
          m_ready = 1; m_ri = 0; m_rp = pc; m_ra = 1;
        end else begin
          m_req = 1; m_addr = pc; m_ra = 0;
        end
`else
        m_req = 1; m_addr = pc; m_ra = 0;
`endif
      end
    end
  end

  // Per-cycle comparison, shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    chk("m_inst_req", {31'b0, inst_req}, {31'b0, m_req});
    if (m_req) chk("m_inst_addr", inst_addr, m_addr);
    chk("m_stallreq", {31'b0, stallreq_if}, {31'b0, ce && !m_ready});
    chk("m_id_pc", id_pc, m_id_pc);
    chk("m_id_inst", id_inst, m_id_inst);
    chk("m_id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    chk("m_id_adel", {31'b0, id_adel}, {31'b0, m_id_adel});
  end

  // Drive one cycle of inputs, then wait for the next falling edge.
  task automatic step(input logic c, input logic a, input logic d,
                      input logic [31:0] rd, input logic [5:0] st, input logic f);
    ce = c; inst_addr_ok = a; inst_data_ok = d; inst_rdata = rd; stall = st; flush = f;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; pc = 32'h0; ce = 0; stall = 6'd0; flush = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fetch: word reaches ID on the 4th edge after ce rises.
    pc = 32'hbfc00000;
    step(1, 0, 0, 32'h0, 6'd0, 0);
    chk("a_req", {31'b0, inst_req}, 32'd1);
    chk("a_addr", inst_addr, 32'hbfc00000);
    step(1, 1, 0, 32'h0, 6'd0, 0);
    step(1, 0, 1, 32'h3c1d0000, 6'd0, 0);
    chk("a_not_yet", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("a_id_inst", id_inst, 32'h3c1d0000);
    chk("a_id_pc", id_pc, 32'hbfc00000);
    chk("a_id_valid", {31'b0, id_valid}, 32'd1);

    // Slow address accept while ID holds the previous word.
    pc = 32'hbfc00004;
    step(1, 0, 0, 32'h0, 6'b000111, 0);
    for (int i = 0; i < 4; i++) begin
      chk("b_req_held", {31'b0, inst_req}, 32'd1);
      chk("b_addr_held", inst_addr, 32'hbfc00004);
      chk("b_stallreq", {31'b0, stallreq_if}, 32'd1);
      if (i < 3) step(1, 0, 0, 32'h0, 6'b000111, 0);
    end
    step(1, 1, 0, 32'h0, 6'b000111, 0);
    step(1, 0, 1, 32'h27bdfff8, 6'b000111, 0);
    chk("b_full_stallreq", {31'b0, stallreq_if}, 32'd0);
    step(0, 0, 0, 32'h0, 6'b000111, 0);
    chk("b_hold_inst", id_inst, 32'h3c1d0000);
    chk("b_hold_valid", {31'b0, id_valid}, 32'd1);
    step(0, 0, 0, 32'h0, 6'b000011, 0);
    chk("b_bubble_inst", id_inst, 32'h0);
    chk("b_bubble_valid", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("b_id_inst", id_inst, 32'h27bdfff8);
    chk("b_id_pc", id_pc, 32'hbfc00004);

    // Flush during the data phase drops the returned word.
    pc = 32'hbfc00008;
    step(1, 0, 0, 32'h0, 6'd0, 0);
    step(1, 1, 0, 32'h0, 6'd0, 0);
    step(1, 0, 0, 32'h0, 6'd0, 1);
    pc = 32'hbfc00100;
    step(1, 0, 1, 32'h24010001, 6'd0, 0);
    chk("c_dropped_valid", {31'b0, id_valid}, 32'd0);
    chk("c_dropped_inst", id_inst, 32'h0);
    step(1, 0, 0, 32'h0, 6'd0, 0);
    chk("c_new_req", {31'b0, inst_req}, 32'd1);
    chk("c_new_addr", inst_addr, 32'hbfc00100);
    // Address and data accepted together.
    step(1, 1, 1, 32'h11112222, 6'd0, 0);
    chk("c_same_cycle_req", {31'b0, inst_req}, 32'd0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("c_id_inst", id_inst, 32'h11112222);
    chk("c_id_pc", id_pc, 32'hbfc00100);

    // Flush while FULL and ID held: flush wins, buffered word is lost.
    pc = 32'hbfc00200;
    step(1, 0, 0, 32'h0, 6'b000111, 0);
    step(1, 1, 0, 32'h0, 6'b000111, 0);
    step(1, 0, 1, 32'haaaa5555, 6'b000111, 0);
    chk("d_still_held", id_inst, 32'h11112222);
    step(0, 0, 0, 32'h0, 6'b000111, 1);
    chk("d_flush_pc", id_pc, 32'h0);
    chk("d_flush_valid", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("d_no_deliver", {31'b0, id_valid}, 32'd0);

    // Reset in the address phase drops the request without a clock edge.
    pc = 32'hbfc00300;
    step(1, 0, 0, 32'h0, 6'd0, 0);
    chk("e_req_before", {31'b0, inst_req}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("e_req_async", {31'b0, inst_req}, 32'd0);
    chk("e_addr_async", inst_addr, 32'h0);
    ce = 0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 32'hdeadbeef, 6'd0, 0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("e_late_data_valid", {31'b0, id_valid}, 32'd0);
    chk("e_late_data_inst", id_inst, 32'h0);

    // Misaligned fetch address.
    pc = 32'hbfc00002;
`ifdef FETCH_ADDR_ERR_EN
    step(1, 0, 0, 32'h0, 6'd0, 0);
    chk("f_no_req", {31'b0, inst_req}, 32'd0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("f_adel", {31'b0, id_adel}, 32'd1);
    chk("f_inst", id_inst, 32'h0);
    chk("f_pc", id_pc, 32'hbfc00002);
    chk("f_no_req_after", {31'b0, inst_req}, 32'd0);
`else
    step(1, 0, 0, 32'h0, 6'd0, 0);
    chk("f_req", {31'b0, inst_req}, 32'd1);
    step(1, 1, 1, 32'h55aa55aa, 6'd0, 0);
    step(0, 0, 0, 32'h0, 6'd0, 0);
    chk("f_adel", {31'b0, id_adel}, 32'd0);
    chk("f_inst", id_inst, 32'h55aa55aa);
    chk("f_pc", id_pc, 32'hbfc00002);
`endif

    step(0, 0, 0, 32'h0, 6'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_if.md
INST_FETCH_IF -- requirements
Module: inst_fetch_if

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have `pc`, input, 32 bits: fetch address from the PC register.
REQ-004 SHALL have `ce`, input, 1 bit: fetch enable from the PC register (1 = enabled).
REQ-005 SHALL have `stall`, input, 6 bits: CTRL stall vector; bit 1 = IF/ID hold, bit 2 = ID hold.
REQ-006 SHALL have `flush`, input, 1 bit: exception flush from CTRL.
REQ-007 SHALL have `inst_req`, output, 1 bit: bus request valid.
REQ-008 SHALL have `inst_addr`, output, 32 bits: bus request address.
REQ-009 SHALL have `inst_addr_ok`, input, 1 bit: bus has accepted the address.
REQ-010 SHALL have `inst_data_ok`, input, 1 bit: `inst_rdata` is valid this cycle.
REQ-011 SHALL have `inst_rdata`, input, 32 bits: returned instruction word.
REQ-012 SHALL have `stallreq_if`, output, 1 bit: stall request to CTRL.
REQ-013 SHALL have `id_pc`, output, 32 bits: PC passed to ID.
REQ-014 SHALL have `id_inst`, output, 32 bits: instruction passed to ID.
REQ-015 SHALL have `id_valid`, output, 1 bit: the ID payload is a real instruction.
REQ-016 SHALL have `id_adel`, output, 1 bit: fetch address error flag passed to ID.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, ADDR, DATA, FULL.
REQ-018 IDLE: when `ce`=1 and `flush`=0, SHALL latch `pc` into the request address register and go to ADDR; otherwise it stays in IDLE.
REQ-019 ADDR: SHALL drive `inst_req`=1 with `inst_addr` equal to the latched address, held stable, until `inst_addr_ok`=1, then go to DATA.
REQ-020 `inst_req` SHALL be 0 in every state other than ADDR.
REQ-021 DATA: on `inst_data_ok`=1, SHALL capture `inst_rdata` into the buffer and go to FULL.
REQ-022 FULL: when `stall[1]`=0, SHALL load `id_pc` and `id_inst` from the buffer, set `id_valid`=1, and go to IDLE.
REQ-023 `stallreq_if` SHALL equal 1 when `ce`=1 and the state is not FULL; otherwise it is 0 (combinational).
REQ-024 When `stall[1]`=1 and `stall[2]`=0, the ID outputs SHALL become a bubble: `id_valid`, `id_inst` and `id_adel` all 0.
REQ-025 When `stall[1]`=1 and `stall[2]`=1, the ID outputs SHALL hold their values.
REQ-026 When `stall[1]`=0 and the state is not FULL, the ID outputs SHALL become a bubble.
REQ-027 `flush` in ADDR or DATA SHALL set a discard flag. The transaction still completes on the bus; the returned data is dropped and the FSM returns to IDLE instead of FULL.
REQ-028 `flush` in FULL SHALL send the FSM to IDLE and drop the buffered instruction.
REQ-029 In any state, `flush` SHALL force `id_valid`, `id_inst`, `id_pc` and `id_adel` to 0 on the next edge; this has priority over all stall rules.
REQ-030 `inst_addr_ok` and `inst_data_ok` asserted in the same cycle while in ADDR SHALL take the FSM directly to FULL (or to IDLE if discarding), capturing the data.
REQ-031 Minimum fetch latency SHALL be 3 cycles, IDLE to FULL, with a zero-wait bus.

Reset
REQ-032 While `rst`=0: state = IDLE; discard flag, `inst_req`, `id_valid` and `id_adel` = 0; `inst_addr`, `id_pc`, `id_inst` and the buffer = 32'h0.
REQ-033 Assertion of `rst` mid-transaction SHALL abandon the transaction immediately; late `inst_data_ok` after release, while in IDLE, SHALL be ignored.

Configuration
REQ-034 Macro `FETCH_ADDR_ERR_EN` defined: in IDLE with `ce`=1 and `pc[1:0]`≠0, SHALL issue no bus request, go directly to FULL with buffer instruction 32'h0, and present `id_adel`=1 with the ID payload.
REQ-035 Macro `FETCH_ADDR_ERR_EN` undefined: SHALL not check alignment; `id_adel` SHALL be tied to 0.

Verification
REQ-036 Zero-wait bus, `pc`=32'hbfc00000, `ce`=1, `stall`=0 -> `id_inst` = `inst_rdata`, `id_pc`=32'hbfc00000 and `id_valid`=1 on the 4th edge after `ce` rises.
REQ-037 `inst_addr_ok` delayed 3 cycles -> `inst_req` and `inst_addr` held stable for 4 cycles; `stallreq_if`=1 throughout.
REQ-038 `flush`=1 in DATA, then `inst_data_ok` with 32'h24010001 -> data dropped, `id_valid`=0, FSM in IDLE, next request uses the new `pc`.
REQ-039 FULL with `stall`=6'b000111 -> ID outputs hold; with `stall`=6'b000011 -> bubble (`id_inst`=0, `id_valid`=0).
REQ-040 `rst` asserted in ADDR -> `inst_req`=0 immediately, without waiting for `clk`; all outputs reach their reset values.
REQ-041 With `FETCH_ADDR_ERR_EN`, `pc`=32'hbfc00002 -> `inst_req` never asserted; `id_adel`=1, `id_inst`=0 and `id_pc`=32'hbfc00002.
